// File: rtl/bw_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : bw_seq_divider
// Description : Sequential signed restoring divider (2N-bit dividend, N-bit
//               divisor). Works on magnitudes MSB first, then applies the
//               operand signs in a final fix-up cycle. Inverse of the
//               Baugh-Wooley multiplier; also usable as a small signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
module bw_seq_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             exact,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * N - 1);
  localparam logic [2*N-1:0]   MOST_NEG  = {1'b1, {(2*N-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [2*N-1:0]   dvd_mag;    // dividend magnitude, consumed MSB first
  logic [N-1:0]     dvs_mag;    // divisor magnitude
  logic [N:0]       part_rem;   // partial remainder
  logic [2*N-1:0]   quo_sh;     // quotient magnitude being built
  logic [CNT_W-1:0] count;
  logic             neg_quo;    // operand signs differ
  logic             neg_rem;    // dividend negative
  logic             dz_pend;
  logic             ovf_pend;

  logic [N:0]       shifted;
  logic [N+1:0]     diff;

  // One restoring step: shift in next dividend bit and trial-subtract divisor
  always_comb begin
    shifted = {part_rem[N-1:0], dvd_mag[2*N-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs_mag};
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_mag     <= '0;
      dvs_mag     <= '0;
      part_rem    <= '0;
      quo_sh      <= '0;
      count       <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      dz_pend     <= 1'b0;
      ovf_pend    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      exact       <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high during the done cycle; start is ignored there
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            neg_quo     <= dividend[2*N-1] ^ divisor[N-1];
            neg_rem     <= dividend[2*N-1];
            dvd_mag     <= dividend[2*N-1] ? -dividend : dividend;
            dvs_mag     <= divisor[N-1] ? -divisor : divisor;
            part_rem    <= '0;
            quo_sh      <= '0;
            count       <= '0;
            dz_pend     <= (divisor == '0);
            ovf_pend    <= (dividend == MOST_NEG) && (divisor == '1);
            busy        <= 1'b1;
            exact       <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= (divisor == '0) ? FIX : CALC;
          end
        end

        CALC: begin
          part_rem <= diff[N+1] ? shifted : diff[N:0];
          quo_sh   <= {quo_sh[2*N-2:0], ~diff[N+1]};
          dvd_mag  <= {dvd_mag[2*N-2:0], 1'b0};
          count    <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (dz_pend) begin
            quotient    <= '0;
            remainder   <= '0;
            exact       <= 1'b0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            // Magnitude remainder is below |divisor| so it fits in N bits
            quotient    <= neg_quo ? -quo_sh : quo_sh;
            remainder   <= neg_rem ? -part_rem[N-1:0] : part_rem[N-1:0];
            exact       <= (part_rem == '0);
            div_by_zero <= 1'b0;
            overflow    <= ovf_pend;
          end
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
